// File: rtl/paddle_update_sched.sv
// Paddle update scheduler: buffers one clamped Y per player and hands updates
// to the shared bar port only during vertical blanking, round-robin between players.
module paddle_update_sched #(
   parameter int unsigned Y_MAX = 420,
   parameter int unsigned OVF_W = 8
) (
   input  logic             CLK,
   input  logic             resentinho,
   input  logic             frame_blank,
   input  logic             game_en,
   input  logic             req1,
   input  logic             req2,
   input  logic [8:0]       y1,
   input  logic [8:0]       y2,
   output logic             ack1,
   output logic             ack2,
   output logic             upd_valid,
   output logic             upd_sel,
   output logic [8:0]       upd_y,
   input  logic             upd_ready,
   output logic [OVF_W-1:0] ovf1,
   output logic [OVF_W-1:0] ovf2,
   output logic             fsm_state
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OFFER = 1'b1;

   localparam logic [8:0]       Y_LIM   = 9'(Y_MAX);
   localparam logic [OVF_W-1:0] OVF_MAX = '1;
   localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

   logic [1:0]  rst_pipe;
   logic        rst_n;
   logic [0:0]  state;
   logic        rr;
   logic        v1, v2;
   logic [8:0]  s1, s2;
   logic        cap1, cap2;
   logic [8:0]  cy1, cy2;
   logic        grant, gsel, gnt1, gnt2;

   // Assertion is immediate; release is delayed two edges so it lands cleanly on CLK.
   always_ff @(posedge CLK or negedge resentinho) begin
      if (!resentinho) rst_pipe <= 2'b00;
      else             rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_n = rst_pipe[1];

   assign fsm_state = state;

   always_comb begin
      cap1  = req1 & game_en;
      cap2  = req2 & game_en;
      cy1   = (y1 > Y_LIM) ? Y_LIM : y1;
      cy2   = (y2 > Y_LIM) ? Y_LIM : y2;
      grant = (state == IDLE) & frame_blank & game_en & (v1 | v2);
      gsel  = (v1 & v2) ? rr : v2;
      gnt1  = grant & ~gsel;
      gnt2  = grant & gsel;
   end

   // A capture in the same cycle as a grant wins the slot; the grant ships the old value.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         s1   <= '0;
         ovf1 <= '0;
         ack1 <= 1'b0;
      end else begin
         ack1 <= cap1;
         if (cap1 && v1 && !gnt1 && ovf1 != OVF_MAX) ovf1 <= ovf1 + OVF_ONE;
         if (!game_en) begin
            v1 <= 1'b0;
         end else if (cap1) begin
            v1 <= 1'b1;
            s1 <= cy1;
         end else if (gnt1) begin
            v1 <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         v2   <= 1'b0;
         s2   <= '0;
         ovf2 <= '0;
         ack2 <= 1'b0;
      end else begin
         ack2 <= cap2;
         if (cap2 && v2 && !gnt2 && ovf2 != OVF_MAX) ovf2 <= ovf2 + OVF_ONE;
         if (!game_en) begin
            v2 <= 1'b0;
         end else if (cap2) begin
            v2 <= 1'b1;
            s2 <= cy2;
         end else if (gnt2) begin
            v2 <= 1'b0;
         end
      end
   end

   // Bar port: once upd_valid rises, upd_sel/upd_y hold until the cycle where
   // upd_valid & upd_ready are both high; that cycle is the transfer.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr        <= 1'b0;
         upd_valid <= 1'b0;
         upd_sel   <= 1'b0;
         upd_y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  upd_valid <= 1'b1;
                  upd_sel   <= gsel;
                  upd_y     <= gsel ? s2 : s1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (upd_ready) begin
                  upd_valid <= 1'b0;
                  rr        <= ~rr;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_paddle_update_sched.sv
// Directed bench for paddle_update_sched; expected bar transfers are queued in
// order and matched against every observed handshake.
module tb_paddle_update_sched;

   logic       CLK = 1'b0;
   logic       resentinho;
   logic       frame_blank, game_en, req1, req2, upd_ready;
   logic [8:0] y1, y2;
   logic       ack1, ack2, upd_valid, upd_sel, fsm_state;
   logic [8:0] upd_y;
   logic [2:0] ovf1, ovf2;

   logic [9:0] exp_q[$];
   int         n_assert = 0;
   int         n_fail   = 0;

   paddle_update_sched #(.Y_MAX(420), .OVF_W(3)) dut (
      .CLK(CLK), .resentinho(resentinho), .frame_blank(frame_blank), .game_en(game_en),
      .req1(req1), .req2(req2), .y1(y1), .y2(y2), .ack1(ack1), .ack2(ack2),
      .upd_valid(upd_valid), .upd_sel(upd_sel), .upd_y(upd_y), .upd_ready(upd_ready),
      .ovf1(ovf1), .ovf2(ovf2), .fsm_state(fsm_state)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs final for the coming edge: a transfer seen
   // now completes on that edge.
   task automatic cyc();
      logic [9:0] e;
      if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("xfer_unexpected", {22'b0, upd_sel, upd_y}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("xfer", {22'b0, upd_sel, upd_y}, {22'b0, e});
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(upd_valid), 0);
      check({tag, "_sel"},   32'(upd_sel),   0);
      check({tag, "_y"},     32'(upd_y),     0);
      check({tag, "_ack"},   {30'b0, ack1, ack2}, 0);
      check({tag, "_ovf"},   {26'b0, ovf1, ovf2}, 0);
   endtask

   initial begin
      resentinho = 1'b0; frame_blank = 1'b0; game_en = 1'b0;
      req1 = 1'b0; req2 = 1'b0; y1 = '0; y2 = '0; upd_ready = 1'b0;
      @(negedge CLK);
      cyc();
      check_all_zero("reset");
      check("reset_state", 32'(fsm_state), 0);
      resentinho = 1'b1;
      repeat (3) cyc();

      // single write
      game_en = 1'b1; frame_blank = 1'b1; upd_ready = 1'b1;
      req1 = 1'b1; y1 = 9'd100;
      exp_q.push_back({1'b0, 9'd100});
      cyc();
      check("t1_ack1", 32'(ack1), 1);
      check("t1_valid_early", 32'(upd_valid), 0);
      req1 = 1'b0;
      cyc();
      check("t1_valid", 32'(upd_valid), 1);
      check("t1_sel", 32'(upd_sel), 0);
      check("t1_y", 32'(upd_y), 100);
      check("t1_ack1_pulse", 32'(ack1), 0);
      check("t1_state", 32'(fsm_state), 1);
      check("t1_ovf1", 32'(ovf1), 0);
      cyc();
      check("t1_done", 32'(upd_valid), 0);

      // clamp
      req2 = 1'b1; y2 = 9'd500;
      exp_q.push_back({1'b1, 9'd420});
      cyc();
      check("t2_ack2", 32'(ack2), 1);
      req2 = 1'b0;
      cyc();
      check("t2_sel", 32'(upd_sel), 1);
      check("t2_y", 32'(upd_y), 420);
      cyc();

      // blanking gate and round-robin
      frame_blank = 1'b0;
      req1 = 1'b1; y1 = 9'd10; req2 = 1'b1; y2 = 9'd20;
      cyc();
      check("t3_acks", {30'b0, ack1, ack2}, 3);
      req1 = 1'b0; req2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("t3_gate", 32'(upd_valid), 0);
      end
      frame_blank = 1'b1;
      exp_q.push_back({1'b0, 9'd10});
      exp_q.push_back({1'b1, 9'd20});
      cyc();
      check("t3_first_sel", 32'(upd_sel), 0);
      repeat (3) cyc();
      req1 = 1'b1; y1 = 9'd421;
      exp_q.push_back({1'b0, 9'd420});
      cyc();
      req1 = 1'b0;
      repeat (2) cyc();
      frame_blank = 1'b0;
      req1 = 1'b1; y1 = 9'd11; req2 = 1'b1; y2 = 9'd21;
      cyc();
      req1 = 1'b0; req2 = 1'b0;
      cyc();
      frame_blank = 1'b1;
      exp_q.push_back({1'b1, 9'd21});
      exp_q.push_back({1'b0, 9'd11});
      cyc();
      check("t3_rr_sel", 32'(upd_sel), 1);
      repeat (3) cyc();
      check("t3_q_empty", 32'(exp_q.size()), 0);

      // overwrite and hold
      frame_blank = 1'b0;
      req1 = 1'b1; y1 = 9'd5;
      cyc();
      y1 = 9'd7;
      cyc();
      req1 = 1'b0;
      cyc();
      check("t4_ovf1", 32'(ovf1), 1);
      upd_ready = 1'b0; frame_blank = 1'b1;
      exp_q.push_back({1'b0, 9'd7});
      cyc();
      check("t4_valid", 32'(upd_valid), 1);
      frame_blank = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("t4_hold_valid", 32'(upd_valid), 1);
         check("t4_hold_data", {22'b0, upd_sel, upd_y}, {22'b0, 1'b0, 9'd7});
      end
      upd_ready = 1'b1;
      cyc();
      check("t4_released", 32'(upd_valid), 0);
      frame_blank = 1'b1;
      repeat (2) begin
         cyc();
         check("t4_single", 32'(upd_valid), 0);
      end

      // same-cycle capture and grant
      frame_blank = 1'b0;
      req1 = 1'b1; y1 = 9'd40;
      cyc();
      frame_blank = 1'b1; y1 = 9'd41;
      exp_q.push_back({1'b0, 9'd40});
      exp_q.push_back({1'b0, 9'd41});
      cyc();
      req1 = 1'b0;
      check("t5_grant_old", 32'(upd_y), 40);
      repeat (3) cyc();
      check("t5_no_ovf", 32'(ovf1), 1);
      check("t5_q_empty", 32'(exp_q.size()), 0);

      // flush
      frame_blank = 1'b0;
      req2 = 1'b1; y2 = 9'd50;
      cyc();
      check("t6_ack2", 32'(ack2), 1);
      req2 = 1'b0; game_en = 1'b0;
      cyc();
      req1 = 1'b1; y1 = 9'd60;
      cyc();
      check("t6_no_ack", 32'(ack1), 0);
      req1 = 1'b0; frame_blank = 1'b1;
      repeat (3) begin
         cyc();
         check("t6_disabled", 32'(upd_valid), 0);
      end
      game_en = 1'b1;
      repeat (2) begin
         cyc();
         check("t6_flushed", 32'(upd_valid), 0);
      end

      // overflow saturation
      frame_blank = 1'b0;
      req2 = 1'b1; y2 = 9'd100;
      repeat (10) cyc();
      req2 = 1'b0;
      cyc();
      check("t7_sat", 32'(ovf2), 7);
      game_en = 1'b0;
      cyc();
      game_en = 1'b1; frame_blank = 1'b1;
      repeat (2) begin
         cyc();
         check("t7_flushed", 32'(upd_valid), 0);
      end

      // reset during OFFER
      upd_ready = 1'b0;
      req1 = 1'b1; y1 = 9'd70;
      cyc();
      req1 = 1'b0;
      cyc();
      check("t8_offer_valid", 32'(upd_valid), 1);
      check("t8_offer_y", 32'(upd_y), 70);
      #2 resentinho = 1'b0;
      #1;
      check_all_zero("t8_async");
      @(negedge CLK);
      repeat (2) begin
         cyc();
         check_all_zero("t8_held");
      end
      resentinho = 1'b1; upd_ready = 1'b1;
      repeat (3) cyc();
      check_all_zero("t8_after");
      check("t8_state", 32'(fsm_state), 0);
      check("final_q_empty", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
